instr_decode_queue: RTL
=======================

// Module: instr_decode_queue
// PURPOSE
//  Parametrised, buffered successor to the combinational immediate-source decoder.
//  - Accepts 32-bit RV32I/RV64I instructions over a valid/ready handshake.
//  - Classifies the opcode into an immsrc class and builds the sign-extended immediate (XLEN wide).
//  - Stores decoded entries in a DEPTH-entry FIFO that feeds the execute stage.
//  - Sits between instruction fetch and the register-file/ALU stage.
// PARAMETERS
//  XLEN   32  immediate/datapath width; legal values 32 or 64
//  DEPTH  4   FIFO entries; power of 2, >= 2
//  CNT_W  8   width of the saturating illegal-instruction counter
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  reset       in   1      asynchronous, active-high; clears all state immediately
//  flush       in   1      synchronous queue clear (branch redirect)
//  in_valid    in   1      in_instr is valid
//  in_ready    out  1      queue can accept this cycle
//  in_instr    in   32     raw instruction word
//  out_valid   out  1      head entry valid
//  out_ready   in   1      consumer takes head this cycle
//  out_op      out  7      head opcode (instr[6:0])
//  out_rd      out  5      head rd (instr[11:7])
//  out_immsrc  out  3      head immediate class
//  out_imm     out  XLEN   head sign-extended immediate
//  out_illegal out  1      head opcode not recognised (macro only, else 0)
//  ill_count   out  CNT_W  saturating count of accepted illegal opcodes (macro only, else 0)
// BEHAVIOUR
//  - immsrc map:
//    - 0110011, 0010011, 0000011, 1100111 -> 000 (I)
//    - 0100011 -> 001 (S)
//    - 1100011 -> 010 (B)
//    - 1101111 -> 011 (J)
//    - 0010111, 0110111 -> 100 (U)
//    - any other opcode -> 000, flagged illegal. Never drive x.
//  - Immediate construction (all sign-extended from instr[31] to XLEN):
//    - I: instr[31:20]
//    - S: {instr[31:25], instr[11:7]}
//    - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
//    - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
//    - U: {instr[31:12], 12'b0}
//    - R-type (0110011) and illegal opcodes: imm = 0.
//  - Decode is combinational on in_instr. The result is written at the accept edge (in_valid & in_ready).
//  - Latency: an entry accepted into an empty queue appears at the head, with out_valid=1, the next cycle.
//  - FIFO:
//    - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.
//    - in_ready = (count != DEPTH), derived from registered count only.
//    - out_valid = (count != 0).
//    - Pop occurs on out_valid & out_ready.
//  - Simultaneous push and pop:
//    - Not full and not empty: count unchanged; both pointers advance.
//    - Full: no push possible (in_ready=0). in_ready rises the cycle after the pop.
//    - Empty: no pop; the pushed entry appears next cycle (no bypass).
//  - Output hold: while out_valid=1 and out_ready=0, all out_* stay stable.
//  - flush:
//    - Next edge: count=0 and both pointers=0.
//    - A push in the same cycle is dropped.
//    - ill_count is NOT cleared.
//    - flush has priority over push and pop.
//  - reset (asynchronous, any time, including mid-transfer):
//    - count=0, pointers=0, ill_count=0.
//    - out_valid=0, in_ready=1; out_op, out_rd, out_immsrc, out_imm and out_illegal all read 0.
//    - Stale FIFO storage is never visible.
// CONFIGURATION
//  INSTR_DEC_ILLEGAL_TRAP_EN defined:
//    - An accepted illegal opcode stores out_illegal=1 and increments ill_count, saturating at all-ones.
//    - The queue then stalls intake: in_ready=0 from the next cycle until flush or reset.
//    - The illegal entry and older entries still drain normally.
//  INSTR_DEC_ILLEGAL_TRAP_EN undefined:
//    - out_illegal and ill_count are tied to 0.
//    - Illegal opcodes pass through as immsrc=000, imm=0, with no stall.
// TESTING
//  1. reset, push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, immsrc=000, imm=0xFFFFFFFF, rd=1.
//  2. push 0x00112623, 0xFE000EE3, 0x008000EF, 0x123452B7, out_ready=1 -> in order:
//     - (001, 0x0000000C)
//     - (010, 0xFFFFFFFC)
//     - (011, 0x00000008)
//     - (100, 0x12345000)
//     XLEN=64 -> upper 32 bits sign-extend.
//  3. DEPTH=4, out_ready=0, push 5 words -> in_ready=0 after 4th accept, 5th held; one pop -> in_ready=1 next cycle, order preserved.
//  4. 2 entries queued, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, pushed word dropped.
//  5. push 0x0000007F:
//     - macro on -> out_illegal=1, ill_count=1, in_ready=0 until flush.
//     - macro off -> immsrc=000, imm=0, no stall.
//     - 255+ illegals (CNT_W=8, macro on, flush between) -> ill_count holds at 0xFF.
//  6. 3 entries queued, assert reset mid-cycle -> out_valid=0, in_ready=1, ill_count=0 immediately, no clock edge required.

Source files
------------

// File: rtl/instr_decode_queue.sv
// Immediate-source decoder feeding a DEPTH-entry FIFO toward execute.
// Optional illegal-opcode trap: define INSTR_DEC_ILLEGAL_TRAP_EN.
module instr_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_op,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_immsrc,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] ill_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic            ill;
    logic [XLEN-1:0] imm;
    logic [2:0]      src;
    logic [4:0]      rd;
    logic [6:0]      op;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          dec_e;
  ent_t          head;
  logic [31:0]   imm32;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, not_full;

  always_comb begin
    imm32    = '0;
    dec_e    = '0;
    dec_e.op = in_instr[6:0];
    dec_e.rd = in_instr[11:7];
    case (in_instr[6:0])
      7'b0110011: ;
      7'b0010011, 7'b0000011, 7'b1100111: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_e.src = 3'b001;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                 in_instr[11:7]};
      end
      7'b1100011: begin
        dec_e.src = 3'b010;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                 in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b1101111: begin
        dec_e.src = 3'b011;
        imm32 = {{11{in_instr[31]}}, in_instr[31],
                 in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      end
      7'b0010111, 7'b0110111: begin
        dec_e.src = 3'b100;
        imm32 = {in_instr[31:12], 12'b0};
      end
      default: begin
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
        dec_e.ill = 1'b1;
`endif
      end
    endcase
    dec_e.imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
  end

  assign not_full  = (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= dec_e;
  end

  // Gate with out_valid so stale storage never reaches the ports.
  assign head        = out_valid ? mem_q[rptr_q] : '0;
  assign out_op      = head.op;
  assign out_rd      = head.rd;
  assign out_immsrc  = head.src;
  assign out_imm     = head.imm;
  assign out_illegal = head.ill;

`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
  logic             stall_q, stall_d;
  logic [CNT_W-1:0] ill_q, ill_d;

  always_comb begin
    stall_d = stall_q;
    ill_d   = ill_q;
    if (flush) begin
      stall_d = 1'b0;
    end else if (push && dec_e.ill) begin
      stall_d = 1'b1;
      if (!(&ill_q)) ill_d = ill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 1'b0;
      ill_q   <= '0;
    end else begin
      stall_q <= stall_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready  = not_full & ~stall_q;
  assign ill_count = ill_q;
`else
  assign in_ready  = not_full;
  assign ill_count = '0;
`endif

endmodule
